rs232_avm_slave: RTL and testbench

//  Avalon-MM slave UART; host side of the RSA256 link. The RSA Avalon master polls

---
 rtl/rs232_avm_slave.sv | 254 +++++++++++++++++++++++++
 tb/tb_rs232_avm_slave.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_avm_slave.sv
// Avalon-MM slave UART (8N1) for the RSA256 host link.
// Register map: 0 = RX byte (read), 4 = TX byte (write), 8 = STATUS (read).
// Bus handshake: a request (avm_read or avm_write held high) is seen with
// avm_waitrequest=1. On the next clock edge it is accepted: side effects are
// committed and readdata is registered. avm_waitrequest is then 0 for exactly one
// cycle, and returns to 1 the cycle after, even if the request is still held.
// A held request therefore restarts as a fresh access every second cycle.
// Read wins when read and write are asserted together.
module rs232_avm_slave #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        avm_clk,
    input  logic        avm_rst_n,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    output logic [31:0] avm_readdata,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic        avm_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [4:0] ADDR_RX     = 5'd0;
    localparam logic [4:0] ADDR_TX     = 5'd4;
    localparam logic [4:0] ADDR_STATUS = 5'd8;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // bus side
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_acc, wr_acc, rx_rd, tx_wr;
    // rx side
    logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_commit;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_full_q, rx_full_d, roe_q, roe_d, fe_q, fe_d;
    // tx side
    tx_state_t   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_load;
    logic [7:0]  tx_hold_q, tx_hold_d;
    logic        tx_full_q, tx_full_d;
    logic        txd_q, txd_d;

    logic        wdata_unused;
    assign wdata_unused    = ^avm_writedata[31:8];

    assign avm_waitrequest = ~ack_q;
    assign avm_readdata    = rdata_q;
    assign uart_txd        = txd_q;

    // Bus acceptance, one wait state, read data mux.
    always_comb begin
        ack_d   = (avm_read | avm_write) & ~ack_q;
        rd_acc  = ack_d & avm_read;
        wr_acc  = ack_d & avm_write & ~avm_read;
        rx_rd   = rd_acc && (avm_address == ADDR_RX);
        tx_wr   = wr_acc && (avm_address == ADDR_TX);
        rdata_d = rdata_q;
        if (rd_acc) begin
            case (avm_address)
                ADDR_RX:     rdata_d = {24'b0, rx_byte_q};
                ADDR_STATUS: rdata_d = {24'b0, rx_full_q, ~tx_full_q, 2'b0, roe_q, fe_q, 2'b0};
                default:     rdata_d = '0;
            endcase
        end
    end

    // RX frame receiver: detect start edge, sample mid-bit, check stop bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_commit  = 1'b0;
        fe_d       = fe_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (rx_prev_q && !rx_sync2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync2_q) rx_commit = 1'b1;
                    else            fe_d      = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX holding register: a read frees the slot, so a commit in the same cycle still lands.
    always_comb begin
        rx_byte_d = rx_byte_q;
        rx_full_d = rx_full_q;
        roe_d     = roe_q;
        if (rx_rd) begin
            rx_full_d = 1'b0;
            roe_d     = 1'b0;
        end
        if (rx_commit) begin
            if (!rx_full_q || rx_rd) begin
                rx_byte_d = rx_shift_q;
                rx_full_d = 1'b1;
            end else begin
                roe_d = 1'b1;
            end
        end
    end

    // TX frame sender; txd is registered from the next state to stay glitch free.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (tx_full_q) begin
                    tx_load    = 1'b1;
                    tx_shift_d = tx_hold_q;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b1, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // TX holding register: a write in the shift-load cycle refills the freed slot.
    always_comb begin
        tx_hold_d = tx_hold_q;
        tx_full_d = tx_full_q;
        if (tx_load) tx_full_d = 1'b0;
        if (tx_wr && (!tx_full_q || tx_load)) begin
            tx_hold_d = avm_writedata[7:0];
            tx_full_d = 1'b1;
        end
    end

    // State registers, synchronous active-low reset.
    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_full_q  <= 1'b0;
            roe_q      <= 1'b0;
            fe_q       <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_hold_q  <= '0;
            tx_full_q  <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            rx_sync1_q <= uart_rxd;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_full_q  <= rx_full_d;
            roe_q      <= roe_d;
            fe_q       <= fe_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_hold_q  <= tx_hold_d;
            tx_full_q  <= tx_full_d;
            txd_q      <= txd_d;
        end
    end
endmodule

// File: tb/tb_rs232_avm_slave.sv
// Bench for rs232_avm_slave with CLKS_PER_BIT=4.
// Bus reads push their expected data into exp_q; a monitor compares readdata on each
// read acknowledge. Expected TX bytes go into tx_exp_q; a serial monitor decodes uart_txd.
module tb_rs232_avm_slave;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        uart_rxd;
    logic        uart_txd;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  tx_exp_q[$];
    bit          tx_mon_en = 1'b0;

    rs232_avm_slave #(.CLKS_PER_BIT(CPB)) dut (
        .avm_clk         (clk),
        .avm_rst_n       (rst_n),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic bus_access(input bit rd, input bit wr, input logic [4:0] addr,
                              input logic [31:0] data);
        bit acked;
        acked = 1'b0;
        @(negedge clk);
        avm_read      = rd;
        avm_write     = wr;
        avm_address   = addr;
        avm_writedata = data;
        for (int i = 0; i < 20 && !acked; i++) begin
            @(negedge clk);
            if (!avm_waitrequest) acked = 1'b1;
        end
        check("bus_ack", {31'b0, acked}, 32'd1);
        @(posedge clk);
        #1;
        avm_read  = 1'b0;
        avm_write = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [4:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus_access(1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        bus_access(1'b0, 1'b1, addr, data);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rxd = f[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    // scoreboard: read data monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && avm_read === 1'b1 && avm_waitrequest === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got 0x%08h, expected no read ack", avm_readdata);
                end else begin
                    check(name_q.pop_front(), avm_readdata, exp_q.pop_front());
                end
            end
        end
    end

    // scoreboard: serial TX monitor, every bit must hold for CPB cycles
    initial begin
        logic [7:0] eb;
        logic [9:0] ef;
        logic [3:0] s;
        forever begin
            @(negedge clk);
            if (tx_mon_en && uart_txd === 1'b0) begin
                if (tx_exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got a start bit, expected idle line");
                    eb = 8'h00;
                end else begin
                    eb = tx_exp_q.pop_front();
                end
                ef = {1'b1, eb, 1'b0};
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < CPB; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge clk);
                        s[k] = uart_txd;
                    end
                    check($sformatf("tx_0x%02h_bit%0d", eb, b), {28'b0, s}, {28'b0, {4{ef[b]}}});
                end
            end
        end
    end

    // main stimulus
    initial begin
        rst_n         = 1'b0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        uart_rxd      = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_waitrequest", {31'b0, avm_waitrequest}, 32'd1);
        check("reset_readdata", avm_readdata, 32'h0);
        check("reset_txd", {31'b0, uart_txd}, 32'd1);
        rst_n = 1'b1;

        // 1: reset in the middle of a TX frame
        write_reg(5'd4, 32'h55);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_rst_txd", {31'b0, uart_txd}, 32'd1);
            check("t1_rst_waitrequest", {31'b0, avm_waitrequest}, 32'd1);
        end
        rst_n = 1'b1;
        tx_mon_en = 1'b1;
        read_expect("t1_status", 5'd8, 32'h40);

        // 2: receive 0xA5
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        read_expect("t2_status_full", 5'd8, 32'hC0);
        read_expect("t2_rx", 5'd0, 32'hA5);
        read_expect("t2_status_empty", 5'd8, 32'h40);

        // 3: transmit 0x3C, refill after shift load, drop a write while full
        tx_exp_q.push_back(8'h3C);
        write_reg(5'd4, 32'h3C);
        tx_exp_q.push_back(8'h77);
        write_reg(5'd4, 32'hFFFF_FF77);
        read_expect("t3_status_txbusy", 5'd8, 32'h00);
        write_reg(5'd4, 32'h99);
        read_expect("t3_status_drop", 5'd8, 32'h00);
        for (int i = 0; i < 400 && tx_exp_q.size() != 0; i++) @(negedge clk);
        check("t3_tx_started", tx_exp_q.size(), 32'd0);
        repeat (60) @(negedge clk);
        read_expect("t3_status_idle", 5'd8, 32'h40);

        // 4: overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        read_expect("t4_status_overrun", 5'd8, 32'hC8);
        read_expect("t4_rx", 5'd0, 32'h11);
        read_expect("t4_status_cleared", 5'd8, 32'h40);
        read_expect("t4_rx_stale", 5'd0, 32'h11);

        // unmapped and read-only addresses
        read_expect("um_read_12", 5'd12, 32'h0);
        read_expect("um_read_tx", 5'd4, 32'h0);
        write_reg(5'd12, 32'h5A);
        write_reg(5'd0, 32'h66);
        read_expect("um_status", 5'd8, 32'h40);
        repeat (20) @(negedge clk);

        // 6: one-cycle rxd glitch, then read+write held at the TX address
        @(negedge clk);
        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            name_q.push_back("t6_rdwr_readdata");
        end
        @(negedge clk);
        avm_read      = 1'b1;
        avm_write     = 1'b1;
        avm_address   = 5'd4;
        avm_writedata = 32'hAB;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("t6_waitrequest_c%0d", k), {31'b0, avm_waitrequest},
                  (k % 2 == 1) ? 32'd0 : 32'd1);
        end
        @(posedge clk);
        #1;
        avm_read  = 1'b0;
        avm_write = 1'b0;
        repeat (10) @(negedge clk);
        read_expect("t6_status", 5'd8, 32'h40);
        repeat (20) @(negedge clk);

        // 5: framing error
        send_frame(8'h5A, 1'b0);
        repeat (4) @(negedge clk);
        read_expect("t5_status_fe", 5'd8, 32'h44);
        read_expect("t5_rx_stale", 5'd0, 32'h11);
        read_expect("t5_status_sticky", 5'd8, 32'h44);

        // final report
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("read_queue_drained", exp_q.size(), 32'd0);
        check("tx_queue_drained", tx_exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
